// File: rtl/corelet_seq.sv
// rtl/corelet_seq.sv - self-sequencing corelet: l0 fifo, weight-stationary MAC array, ofifo, pass accumulator
// Build option: CORELET_SEQ_RELU_EN clamps negative output lanes to zero at the output port only.
module corelet_seq #(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int nij_len = 16,
    parameter int kij_len = 9,
    localparam int KW     = (kij_len > 1) ? $clog2(kij_len) : 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic [row*bw-1:0]      in_w_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    output logic [col*psum_bw-1:0] out_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [KW-1:0]          kij_cnt_o
);
    localparam int LAT  = row + col;
    localparam int L0_D = col;
    localparam int OF_D = nij_len;
    localparam int CMAX = (nij_len > LAT) ? nij_len : LAT;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int NIW  = (nij_len > 1) ? $clog2(nij_len) : 1;
    localparam int LPW  = (L0_D > 1) ? $clog2(L0_D) : 1;
    localparam int LCW  = $clog2(L0_D + 1);
    localparam int OPW  = (OF_D > 1) ? $clog2(OF_D) : 1;
    localparam int OCW  = $clog2(OF_D + 1);
    localparam int IFW  = $clog2(LAT + 1);
    localparam int WIW  = (col > 1) ? $clog2(col) : 1;

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_LOAD_W, S_WFLUSH, S_EXEC, S_DRAIN, S_OUT} state_t;

    state_t                 state_q;
    logic [KW-1:0]          kij_q;
    logic [CW-1:0]          cnt_q;
    logic                   busy_q, done_q, out_valid_q;

    logic [row*bw-1:0]      l0_mem [L0_D];
    logic [LPW-1:0]         l0_wp_q, l0_rp_q;
    logic [LCW-1:0]         l0_cnt_q;
    logic [row*bw-1:0]      w_q [col];
    logic [WIW-1:0]         wcol_q;
    logic [col*psum_bw-1:0] pipe_d_q [LAT];
    logic [LAT-1:0]         pipe_v_q;
    logic [IFW-1:0]         infl_q;
    logic [col*psum_bw-1:0] of_mem [OF_D];
    logic [OPW-1:0]         of_wp_q, of_rp_q;
    logic [OCW-1:0]         of_cnt_q;
    logic [col*psum_bw-1:0] acc_q [nij_len];

    logic                   l0_full, l0_empty, l0_wr, l0_rd, issue, of_push, of_pop, out_acc;
    logic [row*bw-1:0]      l0_head;
    logic [col*psum_bw-1:0] dot, of_head, acc_next, acc_sel;
    logic [psum_bw-1:0]     sum, a_ext, w_ext;

    assign l0_full    = (l0_cnt_q == LCW'(L0_D));
    assign l0_empty   = (l0_cnt_q == '0);
    assign l0_head    = l0_mem[l0_rp_q];
    assign in_ready_o = ((state_q == S_LOAD_W) || (state_q == S_EXEC)) && !l0_full;
    assign l0_wr      = in_valid_i && in_ready_o;
    // Issue only when the ofifo has room for everything already in flight, so no result is dropped.
    assign issue      = ((state_q == S_EXEC) || (state_q == S_DRAIN)) && !l0_empty &&
                        ((int'(of_cnt_q) + int'(infl_q)) < OF_D);
    assign l0_rd      = issue || ((state_q == S_WFLUSH) && !l0_empty);
    assign of_push    = pipe_v_q[LAT-1];
    assign of_pop     = (state_q == S_DRAIN) && (of_cnt_q != '0);
    assign of_head    = of_mem[of_rp_q];
    assign out_acc    = out_valid_q && out_ready_i;
    assign acc_sel    = acc_q[cnt_q[NIW-1:0]];

    // Activations are unsigned, weights signed; column c word holds w[r][c] in lane r.
    always_comb begin
        dot   = '0;
        sum   = '0;
        a_ext = '0;
        w_ext = '0;
        for (int c = 0; c < col; c++) begin
            sum = '0;
            for (int r = 0; r < row; r++) begin
                a_ext = {{(psum_bw-bw){1'b0}}, l0_head[r*bw +: bw]};
                w_ext = {{(psum_bw-bw){w_q[c][r*bw+bw-1]}}, w_q[c][r*bw +: bw]};
                sum   = sum + a_ext * w_ext;
            end
            dot[c*psum_bw +: psum_bw] = sum;
        end
    end

    always_comb begin
        acc_next = '0;
        for (int c = 0; c < col; c++) begin
            acc_next[c*psum_bw +: psum_bw] = (kij_q == '0) ? of_head[c*psum_bw +: psum_bw]
                : acc_sel[c*psum_bw +: psum_bw] + of_head[c*psum_bw +: psum_bw];
        end
    end

    always_comb begin
        out_o = '0;
        if (out_valid_q) begin
`ifdef CORELET_SEQ_RELU_EN
            for (int c = 0; c < col; c++) begin
                out_o[c*psum_bw +: psum_bw] = acc_sel[c*psum_bw+psum_bw-1] ? '0 : acc_sel[c*psum_bw +: psum_bw];
            end
`else
            out_o = acc_sel;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            l0_wp_q  <= '0;
            l0_rp_q  <= '0;
            l0_cnt_q <= '0;
        end else begin
            if (l0_wr) begin
                l0_mem[l0_wp_q] <= in_w_i;
                l0_wp_q <= (l0_wp_q == LPW'(L0_D - 1)) ? '0 : l0_wp_q + LPW'(1);
            end
            if (l0_rd) l0_rp_q <= (l0_rp_q == LPW'(L0_D - 1)) ? '0 : l0_rp_q + LPW'(1);
            l0_cnt_q <= l0_cnt_q + LCW'(l0_wr) - LCW'(l0_rd);
        end
    end

    // CLR acts as the array reset: weights, pipeline and ofifo start each pass empty.
    always_ff @(posedge clk_i) begin
        if (reset_i || (state_q == S_CLR)) begin
            pipe_v_q <= '0;
            infl_q   <= '0;
            wcol_q   <= '0;
            of_wp_q  <= '0;
            of_rp_q  <= '0;
            of_cnt_q <= '0;
            for (int c = 0; c < col; c++) w_q[c] <= '0;
        end else begin
            if ((state_q == S_WFLUSH) && l0_rd) begin
                w_q[wcol_q] <= l0_head;
                wcol_q      <= wcol_q + WIW'(1);
            end
            pipe_v_q    <= {pipe_v_q[LAT-2:0], issue};
            pipe_d_q[0] <= dot;
            for (int i = 1; i < LAT; i++) pipe_d_q[i] <= pipe_d_q[i-1];
            infl_q <= infl_q + IFW'(issue) - IFW'(of_push);
            if (of_push) begin
                of_mem[of_wp_q] <= pipe_d_q[LAT-1];
                of_wp_q <= (of_wp_q == OPW'(OF_D - 1)) ? '0 : of_wp_q + OPW'(1);
            end
            if (of_pop) of_rp_q <= (of_rp_q == OPW'(OF_D - 1)) ? '0 : of_rp_q + OPW'(1);
            of_cnt_q <= of_cnt_q + OCW'(of_push) - OCW'(of_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (of_pop) acc_q[cnt_q[NIW-1:0]] <= acc_next;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            kij_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q <= S_CLR;
                        kij_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_CLR: state_q <= S_LOAD_W;
                S_LOAD_W: begin
                    if (l0_wr) begin
                        if (cnt_q == CW'(col - 1)) begin
                            cnt_q   <= '0;
                            state_q <= S_WFLUSH;
                        end else cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_WFLUSH: begin
                    if (l0_empty) begin
                        if (cnt_q == CW'(LAT - 1)) begin
                            cnt_q   <= '0;
                            state_q <= S_EXEC;
                        end else cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_EXEC: begin
                    if (l0_wr) begin
                        if (cnt_q == CW'(nij_len - 1)) begin
                            cnt_q   <= '0;
                            state_q <= S_DRAIN;
                        end else cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DRAIN: begin
                    if (of_pop) begin
                        if (cnt_q == CW'(nij_len - 1)) begin
                            cnt_q <= '0;
                            if (kij_q == KW'(kij_len - 1)) begin
                                state_q     <= S_OUT;
                                out_valid_q <= 1'b1;
                            end else begin
                                kij_q   <= kij_q + KW'(1);
                                state_q <= S_CLR;
                            end
                        end else cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_OUT: begin
                    if (out_acc) begin
                        if (cnt_q == CW'(nij_len - 1)) begin
                            cnt_q       <= '0;
                            kij_q       <= '0;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= S_IDLE;
                        end else cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_valid_o = out_valid_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign kij_cnt_o   = kij_q;
endmodule

// File: tb/tb_corelet_seq.sv
// tb/tb_corelet_seq.sv - randomized self-checking bench for corelet_seq against a dot-product reference model
module tb_corelet_seq;
    localparam int BW = 4, PSUM_BW = 16, ROW = 8, COL = 8, NIJ = 16, KIJ = 9;
    localparam int BUDGET = 6000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start9, start1, in_valid, out_ready;
    logic [ROW*BW-1:0] in_w;
    logic in_ready9, out_valid9, busy9, done9, in_ready1, out_valid1, busy1, done1;
    logic [COL*PSUM_BW-1:0] out9, out1;
    logic [3:0] kij9;
    logic [0:0] kij1;
    bit sel;

    corelet_seq #(.bw(BW), .psum_bw(PSUM_BW), .row(ROW), .col(COL), .nij_len(NIJ), .kij_len(KIJ)) u_dut9 (
        .clk_i(clk), .reset_i(reset), .start_i(start9), .in_w_i(in_w), .in_valid_i(in_valid),
        .in_ready_o(in_ready9), .out_o(out9), .out_valid_o(out_valid9), .out_ready_i(out_ready),
        .busy_o(busy9), .done_o(done9), .kij_cnt_o(kij9));
    corelet_seq #(.bw(BW), .psum_bw(PSUM_BW), .row(ROW), .col(COL), .nij_len(NIJ), .kij_len(1)) u_dut1 (
        .clk_i(clk), .reset_i(reset), .start_i(start1), .in_w_i(in_w), .in_valid_i(in_valid),
        .in_ready_o(in_ready1), .out_o(out1), .out_valid_o(out_valid1), .out_ready_i(out_ready),
        .busy_o(busy1), .done_o(done1), .kij_cnt_o(kij1));

    logic in_ready_s, out_valid_s, busy_s, done_s;
    logic [COL*PSUM_BW-1:0] out_s;
    assign in_ready_s  = sel ? in_ready1 : in_ready9;
    assign out_valid_s = sel ? out_valid1 : out_valid9;
    assign busy_s      = sel ? busy1 : busy9;
    assign done_s      = sel ? done1 : done9;
    assign out_s       = sel ? out1 : out9;

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    int W [KIJ][COL][ROW];
    int A [KIJ][NIJ][ROW];
    logic [PSUM_BW-1:0] exp_v [NIJ][COL];
    logic [COL*PSUM_BW-1:0] got [NIJ];
    int n_got, stall_seen, done_cnt;
    bit timeout, stall_bad, done_next, done_after, feed_done;
    int kij_seq[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done_s) done_cnt++;
        if (!sel && busy9 && (kij_seq.size() == 0 || kij_seq[$] != int'(kij9))) kij_seq.push_back(int'(kij9));
    end

    task automatic fill_data(input bit rnd, input int wv, input int av);
        for (int k = 0; k < KIJ; k++) begin
            for (int c = 0; c < COL; c++)
                for (int r = 0; r < ROW; r++) W[k][c][r] = rnd ? int'($urandom_range(15)) - 8 : wv;
            for (int n = 0; n < NIJ; n++)
                for (int r = 0; r < ROW; r++) A[k][n][r] = rnd ? int'($urandom_range(7)) : av;
        end
    endtask

    // out[n][c] = sum over passes k and rows r of act[k][n][r] * w[k][r][c], wrapped to psum width.
    task automatic compute_expected(input int kj);
        for (int n = 0; n < NIJ; n++) begin
            for (int c = 0; c < COL; c++) begin
                int s = 0;
                for (int k = 0; k < kj; k++)
                    for (int r = 0; r < ROW; r++) s += A[k][n][r] * W[k][c][r];
                exp_v[n][c] = PSUM_BW'(s);
`ifdef CORELET_SEQ_RELU_EN
                if (exp_v[n][c][PSUM_BW-1]) exp_v[n][c] = '0;
`endif
            end
        end
    endtask

    function automatic logic [COL*PSUM_BW-1:0] pack_exp(input int n);
        logic [COL*PSUM_BW-1:0] v;
        for (int c = 0; c < COL; c++) v[c*PSUM_BW +: PSUM_BW] = exp_v[n][c];
        return v;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        if (sel) start1 = 1'b1; else start9 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start9 = 1'b0;
    endtask

    task automatic run_job(input int kj, input int gap_pct, input int stall, input bit noise);
        logic [ROW*BW-1:0] stream[$];
        logic [ROW*BW-1:0] wd;
        int t0;
        stream = {};
        for (int k = 0; k < kj; k++) begin
            for (int c = 0; c < COL; c++) begin
                for (int r = 0; r < ROW; r++) wd[r*BW +: BW] = W[k][c][r][BW-1:0];
                stream.push_back(wd);
            end
            for (int n = 0; n < NIJ; n++) begin
                for (int r = 0; r < ROW; r++) wd[r*BW +: BW] = A[k][n][r][BW-1:0];
                stream.push_back(wd);
            end
        end
        for (int n = 0; n < NIJ; n++) got[n] = 'x;
        n_got = 0; timeout = 0; stall_bad = 0; stall_seen = 0; feed_done = 0;
        done_cnt = 0; kij_seq = {};
        pulse_start();
        t0 = cyc;
        fork
            begin
                int idx = 0;
                while (idx < stream.size() && !timeout) begin
                    @(negedge clk);
                    in_w = stream[idx];
                    in_valid = (int'($urandom_range(99)) >= gap_pct);
                    if (in_valid && in_ready_s) idx++;
                    if (cyc - t0 > BUDGET) timeout = 1;
                end
                @(negedge clk);
                in_valid = 1'b0;
                feed_done = 1;
            end
            begin
                int stall_left = stall;
                out_ready = 1'b0;
                while (n_got < NIJ && !timeout) begin
                    @(negedge clk);
                    if (stall_left > 0 && (out_valid_s || stall_left < stall)) begin
                        if (!out_valid_s || out_s !== pack_exp(0)) stall_bad = 1;
                        out_ready = 1'b0;
                        stall_left--;
                        stall_seen++;
                    end else begin
                        out_ready = ($urandom_range(3) != 0);
                        if (out_valid_s && out_ready) begin
                            got[n_got] = out_s;
                            n_got++;
                        end
                    end
                    if (cyc - t0 > BUDGET) timeout = 1;
                end
                @(negedge clk);
                out_ready = 1'b0;
                done_next = done_s;
                @(negedge clk);
                done_after = done_s;
            end
            begin
                if (noise) begin
                    while (!feed_done && !timeout) begin
                        repeat ($urandom_range(25, 5)) @(negedge clk);
                        if (!feed_done) pulse_start();
                    end
                    repeat (3) @(negedge clk);
                    pulse_start();
                end
            end
        join
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_tests++; if (busy9 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy9); end
        n_tests++; if (in_ready9 !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready9); end
        n_tests++; if (out_valid9 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid9); end
        n_tests++; if (done9 !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done9); end
        n_tests++; if (out9 !== '0) begin n_fail++; $display("FAIL reset_out got %h want 0", out9); end
        n_tests++; if (kij9 !== 4'd0) begin n_fail++; $display("FAIL reset_kij got %0d want 0", kij9); end
        n_tests++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy1 got %b want 0", busy1); end
    endtask

    task automatic test_reset_mid_load();
        int acc = 0, guard = 0;
        bit saw_done = 0;
        sel = 0;
        pulse_start();
        while (acc < 3 && guard < 50) begin
            @(negedge clk);
            in_w = ROW*BW'($urandom);
            in_valid = 1'b1;
            if (in_ready9) acc++;
            guard++;
        end
        n_tests++; if (acc != 3) begin n_fail++; $display("FAIL midload_accepts got %0d want 3", acc); end
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        saw_done = done9;
        n_tests++; if (busy9 !== 1'b0) begin n_fail++; $display("FAIL midload_busy got %b want 0", busy9); end
        n_tests++; if (in_ready9 !== 1'b0) begin n_fail++; $display("FAIL midload_in_ready got %b want 0", in_ready9); end
        repeat (3) begin @(negedge clk); saw_done |= done9; end
        n_tests++; if (saw_done) begin n_fail++; $display("FAIL midload_done got 1 want 0"); end
        fill_data(1, 0, 0);
        compute_expected(KIJ);
        run_job(KIJ, 10, 0, 0);
        n_tests++; if (timeout) begin n_fail++; $display("FAIL restart_timeout got %0d rows want %0d", n_got, NIJ); end
        for (int n = 0; n < NIJ; n++) begin
            n_tests++;
            if (got[n] !== pack_exp(n)) begin n_fail++; $display("FAIL restart_row%0d got %h want %h", n, got[n], pack_exp(n)); end
        end
    endtask

    task automatic test_single_pass();
        sel = 1;
        fill_data(0, 1, 1);
        compute_expected(1);
        run_job(1, 0, 0, 0);
        n_tests++; if (timeout) begin n_fail++; $display("FAIL single_timeout got %0d rows want %0d", n_got, NIJ); end
        for (int n = 0; n < NIJ; n++) begin
            n_tests++;
            if (got[n] !== pack_exp(n)) begin n_fail++; $display("FAIL single_row%0d got %h want %h", n, got[n], pack_exp(n)); end
        end
        n_tests++; if (done_next !== 1'b1) begin n_fail++; $display("FAIL single_done_next got %b want 1", done_next); end
        n_tests++; if (done_after !== 1'b0) begin n_fail++; $display("FAIL single_done_width got %b want 0", done_after); end
        n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL single_done_count got %0d want 1", done_cnt); end
        fill_data(1, 0, 0);
        compute_expected(1);
        run_job(1, 25, 0, 0);
        for (int n = 0; n < NIJ; n++) begin
            n_tests++;
            if (got[n] !== pack_exp(n)) begin n_fail++; $display("FAIL single_rand_row%0d got %h want %h", n, got[n], pack_exp(n)); end
        end
        sel = 0;
    endtask

    task automatic test_accum();
        fill_data(0, 1, 2);
        compute_expected(KIJ);
        run_job(KIJ, 0, 0, 0);
        n_tests++; if (n_got != NIJ) begin n_fail++; $display("FAIL accum_rows got %0d want %0d", n_got, NIJ); end
        for (int n = 0; n < NIJ; n++) begin
            n_tests++;
            if (got[n] !== {COL{16'd144}}) begin n_fail++; $display("FAIL accum_row%0d got %h want %h", n, got[n], {COL{16'd144}}); end
        end
        n_tests++; if (busy9 !== 1'b0) begin n_fail++; $display("FAIL accum_busy_end got %b want 0", busy9); end
        n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL accum_done_count got %0d want 1", done_cnt); end
    endtask

    task automatic test_negative();
        fill_data(0, -1, 3);
        compute_expected(KIJ);
        run_job(KIJ, 15, 0, 0);
        n_tests++; if (timeout) begin n_fail++; $display("FAIL neg_timeout got %0d rows want %0d", n_got, NIJ); end
        for (int n = 0; n < NIJ; n++) begin
            n_tests++;
            if (got[n] !== pack_exp(n)) begin n_fail++; $display("FAIL neg_row%0d got %h want %h", n, got[n], pack_exp(n)); end
        end
    endtask

    task automatic test_stall();
        fill_data(0, 1, 2);
        compute_expected(KIJ);
        run_job(KIJ, 40, 20, 0);
        n_tests++; if (timeout) begin n_fail++; $display("FAIL stall_timeout got %0d rows want %0d", n_got, NIJ); end
        for (int n = 0; n < NIJ; n++) begin
            n_tests++;
            if (got[n] !== pack_exp(n)) begin n_fail++; $display("FAIL stall_row%0d got %h want %h", n, got[n], pack_exp(n)); end
        end
        n_tests++; if (stall_bad) begin n_fail++; $display("FAIL stall_hold got unstable want stable"); end
        n_tests++; if (stall_seen != 20) begin n_fail++; $display("FAIL stall_cycles got %0d want 20", stall_seen); end
    endtask

    task automatic test_start_ignored();
        fill_data(1, 0, 0);
        compute_expected(KIJ);
        run_job(KIJ, 20, 0, 1);
        n_tests++; if (timeout) begin n_fail++; $display("FAIL noise_timeout got %0d rows want %0d", n_got, NIJ); end
        for (int n = 0; n < NIJ; n++) begin
            n_tests++;
            if (got[n] !== pack_exp(n)) begin n_fail++; $display("FAIL noise_row%0d got %h want %h", n, got[n], pack_exp(n)); end
        end
        n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL noise_done_count got %0d want 1", done_cnt); end
        n_tests++; if (kij_seq.size() != KIJ) begin n_fail++; $display("FAIL noise_kij_len got %0d want %0d", kij_seq.size(), KIJ); end
        for (int i = 0; i < kij_seq.size() && i < KIJ; i++) begin
            n_tests++;
            if (kij_seq[i] != i) begin n_fail++; $display("FAIL noise_kij%0d got %0d want %0d", i, kij_seq[i], i); end
        end
        repeat (5) @(negedge clk);
        n_tests++; if (busy9 !== 1'b0) begin n_fail++; $display("FAIL noise_idle_after got busy %b want 0", busy9); end
    endtask

    initial begin
        reset = 1'b1; start9 = 1'b0; start1 = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_w = '0; sel = 0;
        test_reset();
        test_reset_mid_load();
        test_single_pass();
        test_accum();
        test_negative();
        test_stall();
        test_start_ignored();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
